// File: rtl/sched_pkg.sv
// Shared types and constants for the HDMI data-island packet slot scheduler.
package sched_pkg;

  localparam int NULL_PACKET_INDEX  = 0;
  localparam int MAX_SLOTS_PER_LINE = 18;
  localparam int SLOTS_USED_W       = 5;

  // slots_used saturates here rather than wrapping.
  localparam logic [SLOTS_USED_W-1:0] SLOTS_USED_MAX = 5'd31;

  typedef enum logic {
    WAIT_FRAME = 1'b0,
    RUN        = 1'b1
  } sched_state_t;

endpackage

// File: rtl/packet_slot_scheduler_if.sv
// Bus between the timing/slot generator (master) and the slot scheduler (slave).
//
// Slot handshake: slot_strobe is a one-cycle request for a decision and is
// never back-pressured. Exactly one cycle later the scheduler pulses
// slot_valid together with the new packet_index (0 = null packet), and pulses
// ack one-hot for the granted source (all zero on a null slot). A source seeing
// its ack bit must advance req/data before the next slot_strobe. packet_index
// holds its value between slot_valid pulses.
interface packet_slot_scheduler_if #(
  parameter int NUM_SOURCES = 4,
  parameter int INDEX_W     = 3
);

  logic                   frame_start;
  logic                   line_start;
  logic                   slot_strobe;
  logic [NUM_SOURCES-1:0] req;
  logic [NUM_SOURCES-1:0] once_mask;
  logic [INDEX_W-1:0]     packet_index;
  logic [NUM_SOURCES-1:0] ack;
  logic                   slot_valid;
  logic [NUM_SOURCES-1:0] frame_sent;
  logic [4:0]             slots_used;

  modport master (
    output frame_start, line_start, slot_strobe, req, once_mask,
    input  packet_index, ack, slot_valid, frame_sent, slots_used
  );

  modport slave (
    input  frame_start, line_start, slot_strobe, req, once_mask,
    output packet_index, ack, slot_valid, frame_sent, slots_used
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches req starting at ptr and
// returns a one-hot grant for the first requester found, plus a valid flag.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic             valid
);

  // Walk the requesters in rotating order from ptr; first hit wins.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      int idx;
      idx = (int'(ptr) + i) % N;
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/packet_slot_scheduler.sv
// Packet slot scheduler: picks which source fills each data-island packet
// slot. Once-per-frame sources (InfoFrames) win by fixed priority; recurring
// sources share the remaining slots round-robin under a per-line budget.
// Optional feature macro: PACKET_SCHED_STARVE_EN (per-source wait counters
// that let a long-waiting recurring source jump the round-robin order).
module packet_slot_scheduler
  import sched_pkg::*;
#(
  parameter int NUM_SOURCES          = 4,
  parameter int INDEX_W              = 3,
  parameter int MAX_NONNULL_PER_LINE = MAX_SLOTS_PER_LINE,
  parameter int STARVE_LIMIT         = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  packet_slot_scheduler_if.slave bus,
  output sched_state_t           state
);

  localparam int PTR_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
  localparam logic [SLOTS_USED_W-1:0] BUDGET = SLOTS_USED_W'(MAX_NONNULL_PER_LINE);

  sched_state_t              next_state;
  logic [INDEX_W-1:0]        packet_index_q;
  logic [NUM_SOURCES-1:0]    ack_q;
  logic                      slot_valid_q;
  logic [NUM_SOURCES-1:0]    frame_sent_q;
  logic [SLOTS_USED_W-1:0]   slots_used_q;
  logic [PTR_W-1:0]          rr_ptr_q;

  logic [NUM_SOURCES-1:0]    once_elig;
  logic [NUM_SOURCES-1:0]    once_grant;
  logic                      once_valid;
  logic [NUM_SOURCES-1:0]    rec_req;
  logic [NUM_SOURCES-1:0]    rr_grant;
  logic                      rr_valid;
  logic [NUM_SOURCES-1:0]    rec_sel;
  logic                      rec_valid;

  logic                      arbitrate;
  logic [SLOTS_USED_W-1:0]   slots_base;
  logic                      budget_ok;

  logic [NUM_SOURCES-1:0]    grant_next;
  logic                      granted;
  logic                      rec_win;
  logic [INDEX_W-1:0]        index_next;
  logic [PTR_W-1:0]          rr_next;
  logic [NUM_SOURCES-1:0]    frame_sent_next;
  logic [SLOTS_USED_W-1:0]   slots_next;

  // A frame_start landing on a strobe suppresses arbitration for that slot.
  assign arbitrate  = bus.slot_strobe && (state == RUN) && !bus.frame_start;
  // line_start restarts the line count so a coincident slot counts as the first.
  assign slots_base = bus.line_start ? '0 : slots_used_q;
  assign budget_ok  = (slots_base < BUDGET);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= WAIT_FRAME;
    else       state <= next_state;
  end

  // Next-state logic: leave WAIT_FRAME on the first frame_start, then stay in RUN.
  always_comb begin
    next_state = state;
    case (state)
      WAIT_FRAME: if (bus.frame_start) next_state = RUN;
      RUN:        next_state = RUN;
      default:    next_state = WAIT_FRAME;
    endcase
  end

  // Once-class fixed priority: lowest-index eligible source not yet sent this frame.
  always_comb begin
    once_elig  = bus.req & bus.once_mask & ~frame_sent_q;
    once_grant = '0;
    once_valid = 1'b0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (!once_valid && once_elig[i]) begin
        once_grant[i] = 1'b1;
        once_valid    = 1'b1;
      end
    end
  end

  assign rec_req = bus.req & ~bus.once_mask;

  rr_arbiter #(
    .N     (NUM_SOURCES),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req   (rec_req),
    .ptr   (rr_ptr_q),
    .grant (rr_grant),
    .valid (rr_valid)
  );

`ifdef PACKET_SCHED_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]       wait_cnt_q [NUM_SOURCES];
  logic [NUM_SOURCES-1:0] starved;
  logic [NUM_SOURCES-1:0] starve_grant;
  logic                   starve_valid;

  // Starved recurring sources override round-robin, lowest index first.
  always_comb begin
    starve_grant = '0;
    starve_valid = 1'b0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      starved[i] = rec_req[i] && (wait_cnt_q[i] >= LIMIT);
      if (!starve_valid && starved[i]) begin
        starve_grant[i] = 1'b1;
        starve_valid    = 1'b1;
      end
    end
    rec_sel   = starve_valid ? starve_grant : rr_grant;
    rec_valid = rr_valid;
  end

  // Wait counters: count strobes lost to another recurring grant or a null slot.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_SOURCES; i++) wait_cnt_q[i] <= '0;
    end else if (arbitrate) begin
      for (int i = 0; i < NUM_SOURCES; i++) begin
        if (!rec_req[i] || grant_next[i])
          wait_cnt_q[i] <= '0;
        else if (!once_valid && (wait_cnt_q[i] < LIMIT))
          wait_cnt_q[i] <= wait_cnt_q[i] + 1'b1;
      end
    end
  end
`else
  logic unused_starve_limit;
  assign unused_starve_limit = (STARVE_LIMIT > 0);

  // Pure round-robin for the recurring class.
  always_comb begin
    rec_sel   = rr_grant;
    rec_valid = rr_valid;
  end
`endif

  // Output/decision logic: choose the grant and compute next register values.
  always_comb begin
    grant_next = '0;
    if (arbitrate) begin
      if (once_valid)                   grant_next = once_grant;
      else if (rec_valid && budget_ok)  grant_next = rec_sel;
    end
    granted = |grant_next;
    rec_win = granted && !once_valid;

    index_next = packet_index_q;
    if (bus.slot_strobe) begin
      index_next = INDEX_W'(NULL_PACKET_INDEX);
      for (int i = 0; i < NUM_SOURCES; i++)
        if (grant_next[i]) index_next = INDEX_W'(i + 1);
    end

    rr_next = rr_ptr_q;
    for (int i = 0; i < NUM_SOURCES; i++)
      if (rec_win && grant_next[i])
        rr_next = (i == NUM_SOURCES - 1) ? '0 : PTR_W'(i + 1);

    frame_sent_next = frame_sent_q;
    if ((state == RUN) && bus.frame_start)
      frame_sent_next = '0;
    else if (arbitrate && once_valid)
      frame_sent_next = frame_sent_q | once_grant;

    slots_next = slots_base;
    if (granted)
      slots_next = (slots_base == SLOTS_USED_MAX) ? SLOTS_USED_MAX : slots_base + 5'd1;
  end

  // Registered outputs and bookkeeping.
  always_ff @(posedge clock) begin
    if (reset) begin
      packet_index_q <= INDEX_W'(NULL_PACKET_INDEX);
      ack_q          <= '0;
      slot_valid_q   <= 1'b0;
      frame_sent_q   <= '0;
      slots_used_q   <= '0;
      rr_ptr_q       <= '0;
    end else begin
      packet_index_q <= index_next;
      ack_q          <= grant_next;
      slot_valid_q   <= bus.slot_strobe;
      frame_sent_q   <= frame_sent_next;
      slots_used_q   <= slots_next;
      rr_ptr_q       <= rr_next;
    end
  end

  assign bus.packet_index = packet_index_q;
  assign bus.ack          = ack_q;
  assign bus.slot_valid   = slot_valid_q;
  assign bus.frame_sent   = frame_sent_q;
  assign bus.slots_used   = slots_used_q;

endmodule

// File: tb/tb_packet_slot_scheduler.sv
// Directed testbench for packet_slot_scheduler. u_dut uses the default line
// budget (and STARVE_LIMIT=2); u_dut_b shares the same inputs with a budget of 2.
module tb_packet_slot_scheduler;
  import sched_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  sched_state_t state_a;
  sched_state_t state_b;

  packet_slot_scheduler_if #(.NUM_SOURCES(4), .INDEX_W(3)) ifa ();
  packet_slot_scheduler_if #(.NUM_SOURCES(4), .INDEX_W(3)) ifb ();

  assign ifb.frame_start = ifa.frame_start;
  assign ifb.line_start  = ifa.line_start;
  assign ifb.slot_strobe = ifa.slot_strobe;
  assign ifb.req         = ifa.req;
  assign ifb.once_mask   = ifa.once_mask;

  packet_slot_scheduler #(.STARVE_LIMIT(2)) u_dut (
    .clock (clk),
    .reset (rst),
    .bus   (ifa.slave),
    .state (state_a)
  );

  packet_slot_scheduler #(.MAX_NONNULL_PER_LINE(2)) u_dut_b (
    .clock (clk),
    .reset (rst),
    .bus   (ifb.slave),
    .state (state_b)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_frame();
    @(negedge clk);
    ifa.frame_start = 1'b1;
    @(negedge clk);
    ifa.frame_start = 1'b0;
  endtask

  task automatic pulse_line();
    @(negedge clk);
    ifa.line_start = 1'b1;
    @(negedge clk);
    ifa.line_start = 1'b0;
  endtask

  // Strobe after a 32-cycle gap; returns at the negedge where outputs are updated.
  task automatic do_strobe(input logic fs, input logic ls);
    repeat (32) @(negedge clk);
    ifa.slot_strobe = 1'b1;
    ifa.frame_start = fs;
    ifa.line_start  = ls;
    @(negedge clk);
    ifa.slot_strobe = 1'b0;
    ifa.frame_start = 1'b0;
    ifa.line_start  = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (ifa.packet_index !== 3'd0) begin errors++; $display("FAIL reset_index: got %0d expected 0", ifa.packet_index); end
    checks++; if (ifa.ack !== 4'b0000) begin errors++; $display("FAIL reset_ack: got %b expected 0000", ifa.ack); end
    checks++; if (ifa.slot_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", ifa.slot_valid); end
    checks++; if (ifa.frame_sent !== 4'b0000) begin errors++; $display("FAIL reset_frame_sent: got %b expected 0000", ifa.frame_sent); end
    checks++; if (ifa.slots_used !== 5'd0) begin errors++; $display("FAIL reset_slots_used: got %0d expected 0", ifa.slots_used); end
    checks++; if (state_a !== WAIT_FRAME) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state_a, WAIT_FRAME); end
    ifa.req       = 4'b1111;
    ifa.once_mask = 4'b0011;
    for (int s = 0; s < 2; s++) begin
      do_strobe(1'b0, 1'b0);
      checks++; if (ifa.packet_index !== 3'd0) begin errors++; $display("FAIL wait_index[%0d]: got %0d expected 0", s, ifa.packet_index); end
      checks++; if (ifa.ack !== 4'b0000) begin errors++; $display("FAIL wait_ack[%0d]: got %b expected 0000", s, ifa.ack); end
      checks++; if (ifa.slot_valid !== 1'b1) begin errors++; $display("FAIL wait_valid[%0d]: got %b expected 1", s, ifa.slot_valid); end
      checks++; if (state_a !== WAIT_FRAME) begin errors++; $display("FAIL wait_state[%0d]: got %0d expected %0d", s, state_a, WAIT_FRAME); end
    end
  endtask

  task automatic test_once_priority();
    logic [2:0] exp_idx [3];
    logic [3:0] exp_ack [3];
    exp_idx = '{3'd1, 3'd2, 3'd3};
    exp_ack = '{4'b0001, 4'b0010, 4'b0100};
    pulse_frame();
    checks++; if (state_a !== RUN) begin errors++; $display("FAIL run_state: got %0d expected %0d", state_a, RUN); end
    ifa.req       = 4'b0111;
    ifa.once_mask = 4'b0011;
    for (int s = 0; s < 3; s++) begin
      do_strobe(1'b0, 1'b0);
      checks++; if (ifa.packet_index !== exp_idx[s]) begin errors++; $display("FAIL once_index[%0d]: got %0d expected %0d", s, ifa.packet_index, exp_idx[s]); end
      checks++; if (ifa.ack !== exp_ack[s]) begin errors++; $display("FAIL once_ack[%0d]: got %b expected %b", s, ifa.ack, exp_ack[s]); end
    end
    checks++; if (ifa.frame_sent !== 4'b0011) begin errors++; $display("FAIL once_frame_sent: got %b expected 0011", ifa.frame_sent); end
    checks++; if (ifa.slots_used !== 5'd3) begin errors++; $display("FAIL once_slots_used: got %0d expected 3", ifa.slots_used); end
    repeat (5) @(negedge clk);
    checks++; if (ifa.packet_index !== 3'd3) begin errors++; $display("FAIL index_hold: got %0d expected 3", ifa.packet_index); end
    checks++; if (ifa.slot_valid !== 1'b0) begin errors++; $display("FAIL valid_pulse: got %b expected 0", ifa.slot_valid); end
    pulse_frame();
    checks++; if (ifa.frame_sent !== 4'b0000) begin errors++; $display("FAIL frame_clear: got %b expected 0000", ifa.frame_sent); end
    do_strobe(1'b0, 1'b0);
    checks++; if (ifa.packet_index !== 3'd1) begin errors++; $display("FAIL once_again_index: got %0d expected 1", ifa.packet_index); end
    checks++; if (ifa.frame_sent !== 4'b0001) begin errors++; $display("FAIL once_again_sent: got %b expected 0001", ifa.frame_sent); end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_idx [4];
    logic [3:0] exp_ack [4];
    exp_idx = '{3'd3, 3'd4, 3'd3, 3'd4};
    exp_ack = '{4'b0100, 4'b1000, 4'b0100, 4'b1000};
    apply_reset();
    pulse_frame();
    ifa.once_mask = 4'b0000;
    ifa.req       = 4'b1100;
    pulse_line();
    for (int s = 0; s < 4; s++) begin
      do_strobe(1'b0, 1'b0);
      checks++; if (ifa.packet_index !== exp_idx[s]) begin errors++; $display("FAIL rr_index[%0d]: got %0d expected %0d", s, ifa.packet_index, exp_idx[s]); end
      checks++; if (ifa.ack !== exp_ack[s]) begin errors++; $display("FAIL rr_ack[%0d]: got %b expected %b", s, ifa.ack, exp_ack[s]); end
    end
    checks++; if (ifa.slots_used !== 5'd4) begin errors++; $display("FAIL rr_slots_used: got %0d expected 4", ifa.slots_used); end
  endtask

  task automatic test_line_budget();
    logic [2:0] exp_idx [3];
    logic [2:0] exp_idx2 [3];
    logic [4:0] exp_su2 [3];
    exp_idx  = '{3'd3, 3'd4, 3'd0};
    exp_idx2 = '{3'd3, 3'd4, 3'd0};
    exp_su2  = '{5'd1, 5'd2, 5'd2};
    apply_reset();
    pulse_frame();
    ifa.once_mask = 4'b0000;
    ifa.req       = 4'b1100;
    pulse_line();
    for (int s = 0; s < 3; s++) begin
      do_strobe(1'b0, 1'b0);
      checks++; if (ifb.packet_index !== exp_idx[s]) begin errors++; $display("FAIL budget_index[%0d]: got %0d expected %0d", s, ifb.packet_index, exp_idx[s]); end
    end
    checks++; if (ifb.ack !== 4'b0000) begin errors++; $display("FAIL budget_null_ack: got %b expected 0000", ifb.ack); end
    checks++; if (ifb.slots_used !== 5'd2) begin errors++; $display("FAIL budget_slots_used: got %0d expected 2", ifb.slots_used); end
    for (int s = 0; s < 3; s++) begin
      do_strobe(1'b0, (s == 0) ? 1'b1 : 1'b0);
      checks++; if (ifb.packet_index !== exp_idx2[s]) begin errors++; $display("FAIL newline_index[%0d]: got %0d expected %0d", s, ifb.packet_index, exp_idx2[s]); end
      checks++; if (ifb.slots_used !== exp_su2[s]) begin errors++; $display("FAIL newline_slots_used[%0d]: got %0d expected %0d", s, ifb.slots_used, exp_su2[s]); end
    end
  endtask

  task automatic test_frame_collision();
    apply_reset();
    pulse_frame();
    ifa.once_mask = 4'b0011;
    ifa.req       = 4'b1111;
    do_strobe(1'b0, 1'b0);
    checks++; if (ifa.packet_index !== 3'd1) begin errors++; $display("FAIL coll_pre_index: got %0d expected 1", ifa.packet_index); end
    do_strobe(1'b1, 1'b0);
    checks++; if (ifa.packet_index !== 3'd0) begin errors++; $display("FAIL coll_index: got %0d expected 0", ifa.packet_index); end
    checks++; if (ifa.ack !== 4'b0000) begin errors++; $display("FAIL coll_ack: got %b expected 0000", ifa.ack); end
    checks++; if (ifa.slot_valid !== 1'b1) begin errors++; $display("FAIL coll_valid: got %b expected 1", ifa.slot_valid); end
    checks++; if (ifa.frame_sent !== 4'b0000) begin errors++; $display("FAIL coll_frame_sent: got %b expected 0000", ifa.frame_sent); end
    do_strobe(1'b0, 1'b0);
    checks++; if (ifa.packet_index !== 3'd1) begin errors++; $display("FAIL coll_next_index: got %0d expected 1", ifa.packet_index); end
    checks++; if (ifa.ack !== 4'b0001) begin errors++; $display("FAIL coll_next_ack: got %b expected 0001", ifa.ack); end
  endtask

  task automatic test_reset_mid_frame();
    apply_reset();
    checks++; if (state_a !== WAIT_FRAME) begin errors++; $display("FAIL midrst_state: got %0d expected %0d", state_a, WAIT_FRAME); end
    checks++; if (ifa.packet_index !== 3'd0) begin errors++; $display("FAIL midrst_index: got %0d expected 0", ifa.packet_index); end
    checks++; if (ifa.frame_sent !== 4'b0000) begin errors++; $display("FAIL midrst_frame_sent: got %b expected 0000", ifa.frame_sent); end
    checks++; if (ifa.slots_used !== 5'd0) begin errors++; $display("FAIL midrst_slots_used: got %0d expected 0", ifa.slots_used); end
  endtask

  task automatic test_starvation();
    logic [2:0] exp_third;
`ifdef PACKET_SCHED_STARVE_EN
    exp_third = 3'd4;
`else
    exp_third = 3'd3;
`endif
    apply_reset();
    pulse_frame();
    ifa.once_mask = 4'b0000;
    ifa.req       = 4'b1011;
    pulse_line();
    do_strobe(1'b0, 1'b0);
    checks++; if (ifa.packet_index !== 3'd1) begin errors++; $display("FAIL starve_s1: got %0d expected 1", ifa.packet_index); end
    do_strobe(1'b0, 1'b0);
    checks++; if (ifa.packet_index !== 3'd2) begin errors++; $display("FAIL starve_s2: got %0d expected 2", ifa.packet_index); end
    ifa.req = 4'b1111;
    do_strobe(1'b0, 1'b0);
    checks++; if (ifa.packet_index !== exp_third) begin errors++; $display("FAIL starve_s3: got %0d expected %0d", ifa.packet_index, exp_third); end
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    rst             = 1'b1;
    ifa.frame_start = 1'b0;
    ifa.line_start  = 1'b0;
    ifa.slot_strobe = 1'b0;
    ifa.req         = 4'b0000;
    ifa.once_mask   = 4'b0000;
    test_reset();
    test_once_priority();
    test_round_robin();
    test_line_budget();
    test_frame_collision();
    test_reset_mid_frame();
    test_starvation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
